// File: rtl/gcn_mac_pipe.sv
`default_nettype none
// ============================================================================
// gcn_mac_pipe : pipelined unsigned-by-signed multiply / multiply-accumulate
//                with first/last framing, shift+saturate and valid/ready flow.
// Revision     : 1.0
// ============================================================================
module gcn_mac_pipe #(
    parameter int A_W        = 12,
    parameter int B_W        = 17,
    parameter int ACC_W      = 40,
    parameter int OUT_W      = 17,
    parameter int FRAC_SHIFT = 0,
    parameter int MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    input  logic             mode,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat
);

    localparam int P_W  = A_W + B_W;
    localparam int LAST = MUL_STAGES - 1;

    logic advance;

    logic [P_W-1:0] a_ext;
    logic [P_W-1:0] b_ext;
    logic [P_W-1:0] prod;

    logic [P_W-1:0]        mul_p_q [MUL_STAGES];
    logic [MUL_STAGES-1:0] mul_v_q;
    logic [MUL_STAGES-1:0] mul_mode_q;
    logic [MUL_STAGES-1:0] mul_first_q;
    logic [MUL_STAGES-1:0] mul_last_q;

    logic [ACC_W-1:0]        p_ext;
    logic [ACC_W-1:0]        acc_sum;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic signed [ACC_W-1:0] res_q, res_d;
    logic                    res_v_q, res_v_d;

    logic signed [ACC_W-1:0]   shifted;
    logic [ACC_W-OUT_W:0]      hi_bits;
    logic [OUT_W-1:0]          data_d;
    logic                      sat_d;

    logic             out_valid_q;
    logic [OUT_W-1:0] out_data_q;
    logic             out_sat_q;

    // Global stall: every stage moves together or not at all.
    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance && !rst;

    // Operands widened to the product width; the low P_W bits of the
    // two's-complement product are exact.
    assign a_ext = {{B_W{1'b0}}, a};
    assign b_ext = {{A_W{b[B_W-1]}}, b};
    assign prod  = a_ext * b_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_v_q     <= '0;
            mul_mode_q  <= '0;
            mul_first_q <= '0;
            mul_last_q  <= '0;
            for (int i = 0; i < MUL_STAGES; i++) begin
                mul_p_q[i] <= '0;
            end
        end else if (advance) begin
            mul_p_q[0]     <= prod;
            mul_v_q[0]     <= in_valid;
            mul_mode_q[0]  <= mode;
            mul_first_q[0] <= in_first;
            mul_last_q[0]  <= in_last;
            for (int i = 1; i < MUL_STAGES; i++) begin
                mul_p_q[i]     <= mul_p_q[i-1];
                mul_v_q[i]     <= mul_v_q[i-1];
                mul_mode_q[i]  <= mul_mode_q[i-1];
                mul_first_q[i] <= mul_first_q[i-1];
                mul_last_q[i]  <= mul_last_q[i-1];
            end
        end
    end

    always_comb begin
        p_ext              = {ACC_W{mul_p_q[LAST][P_W-1]}};
        p_ext[P_W-1:0]     = mul_p_q[LAST];
        acc_sum            = acc_q + p_ext;
        acc_d              = acc_q;
        res_d              = res_q;
        res_v_d            = 1'b0;
        if (mul_v_q[LAST]) begin
            if (!mul_mode_q[LAST]) begin
                res_d   = p_ext;
                res_v_d = 1'b1;
            end else begin
                acc_d   = mul_first_q[LAST] ? p_ext : acc_sum;
                res_d   = acc_d;
                res_v_d = mul_last_q[LAST];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            res_q   <= '0;
            res_v_q <= 1'b0;
        end else if (advance) begin
            acc_q   <= acc_d;
            res_q   <= res_d;
            res_v_q <= res_v_d;
        end
    end

    // The value fits iff every bit from the OUT_W sign bit upward agrees.
    always_comb begin
        shifted = res_q >>> FRAC_SHIFT;
        hi_bits = shifted[ACC_W-1:OUT_W-1];
        data_d  = shifted[OUT_W-1:0];
        sat_d   = 1'b0;
        if (!((&hi_bits) || !(|hi_bits))) begin
            sat_d  = 1'b1;
            data_d = shifted[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                      : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else if (advance) begin
            out_valid_q <= res_v_q;
            if (res_v_q) begin
                out_data_q <= data_d;
                out_sat_q  <= sat_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_gcn_mac_pipe.sv
`default_nettype none
// Bench for gcn_mac_pipe: three instances (default, FRAC_SHIFT=4, ACC_W=29)
// driven in lockstep; directed scenarios plus a randomized model comparison.
module tb_gcn_mac_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [11:0] a = '0;
    logic [16:0] b = '0;
    logic        mode = 1'b0;
    logic        in_first = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready0, in_ready1, in_ready2;
    logic        out_valid0, out_valid1, out_valid2;
    logic [16:0] out_data0, out_data1, out_data2;
    logic        out_sat0, out_sat1, out_sat2;

    gcn_mac_pipe u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .mode(mode), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_sat(out_sat0)
    );

    gcn_mac_pipe #(.FRAC_SHIFT(4)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .mode(mode), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_sat(out_sat1)
    );

    gcn_mac_pipe #(.ACC_W(29)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .mode(mode), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_sat(out_sat2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [17:0] obs0[$], obs1[$], obs2[$];
    logic [17:0] exp0[$], exp1[$], exp2[$];

    // Reference model: per-instance accumulator and conversion parameters.
    longint macc [3];
    int     accw [3] = '{40, 40, 29};
    int     fsh  [3] = '{0, 4, 0};

    // Record every result transferred on the coming rising edge.
    always @(negedge clk) begin
        if (!rst && out_ready) begin
            if (out_valid0) obs0.push_back({out_sat0, out_data0});
            if (out_valid1) obs1.push_back({out_sat1, out_data1});
            if (out_valid2) obs2.push_back({out_sat2, out_data2});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [17:0] mk(bit s, int v);
        return {s, v[16:0]};
    endfunction

    function automatic longint wrapw(longint v, int w);
        longint m;
        m = longint'(1) << w;
        v = v & (m - 1);
        if (v >= (m >> 1)) v = v - m;
        return v;
    endfunction

    function automatic logic [17:0] conv(longint r, int fs);
        longint s;
        s = r >>> fs;
        if (s > 65535)  return mk(1'b1, 65535);
        if (s < -65536) return mk(1'b1, -65536);
        return {1'b0, s[16:0]};
    endfunction

    function automatic void push_exp(int k, logic [17:0] v);
        case (k)
            0:       exp0.push_back(v);
            1:       exp1.push_back(v);
            default: exp2.push_back(v);
        endcase
    endfunction

    function automatic void model_beat(int av, int bv, bit md, bit f, bit l);
        longint p;
        p = longint'(av) * longint'(bv);
        for (int k = 0; k < 3; k++) begin
            if (!md) begin
                push_exp(k, conv(wrapw(p, accw[k]), fsh[k]));
            end else begin
                macc[k] = f ? wrapw(p, accw[k]) : wrapw(macc[k] + p, accw[k]);
                if (l) push_exp(k, conv(macc[k], fsh[k]));
            end
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) macc[k] = 0;
        exp0.delete(); exp1.delete(); exp2.delete();
    endfunction

    function automatic void clear_q();
        obs0.delete(); obs1.delete(); obs2.delete();
        exp0.delete(); exp1.delete(); exp2.delete();
    endfunction

    // Called at posedge+1; returns at posedge+1 right after acceptance.
    task automatic send(int av, int bv, bit md, bit f, bit l);
        int t;
        t        = 0;
        a        = av[11:0];
        b        = bv[16:0];
        mode     = md;
        in_first = f;
        in_last  = l;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready got 0 want 1 within 200 cycles");
        end else begin
            model_beat(av, bv, md, f, l);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        mode     = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_cycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        a = 12'd5; b = 17'd5; mode = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_ready0 !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready0); end
        n_cmp++; if (out_valid0 !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid0); end
        n_cmp++; if (out_data0 !== 17'd0) begin n_bad++; $display("FAIL rst_out_data: got %0d want 0", out_data0); end
        n_cmp++; if (out_sat0 !== 1'b0) begin n_bad++; $display("FAIL rst_out_sat: got %b want 0", out_sat0); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        n_cmp++; if (in_ready0 !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", in_ready0); end
        wait_cycles(6);
        n_cmp++; if (obs0.size() != 0) begin n_bad++; $display("FAIL rst_no_output: got %0d outputs want 0", obs0.size()); end
        clear_q();
    endtask

    task automatic test_mode0();
        logic [17:0] want[$];
        logic [17:0] got;
        clear_q();
        send(3, -5, 1'b0, 1'b0, 1'b0);
        idle();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid0 !== (c == 3)) begin
                n_bad++;
                $display("FAIL mode0_latency[%0d]: out_valid got %b want %b", c, out_valid0, (c == 3));
            end
        end
        @(posedge clk);
        #1;
        send(4095, -65536, 1'b0, 1'b0, 1'b0);
        send(4095, 65535, 1'b0, 1'b0, 1'b0);
        idle();
        wait_cycles(8);
        want.push_back(mk(1'b0, -15));
        want.push_back(mk(1'b1, -65536));
        want.push_back(mk(1'b1, 65535));
        n_cmp++; if (obs0.size() != want.size()) begin n_bad++; $display("FAIL mode0_count: got %0d want %0d", obs0.size(), want.size()); end
        foreach (want[i]) begin
            got = (i < obs0.size()) ? obs0[i] : 18'bx;
            n_cmp++;
            if (got !== want[i]) begin
                n_bad++;
                $display("FAIL mode0[%0d]: got sat=%b data=%0d want sat=%b data=%0d", i, got[17], $signed(got[16:0]), want[i][17], $signed(want[i][16:0]));
            end
        end
    endtask

    task automatic test_accumulate();
        clear_q();
        send(1, 100, 1'b1, 1'b1, 1'b0);
        send(2, -30, 1'b1, 1'b0, 1'b0);
        send(3, 10, 1'b1, 1'b0, 1'b1);
        idle();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid0 !== (c == 3)) begin
                n_bad++;
                $display("FAIL acc_latency[%0d]: out_valid got %b want %b", c, out_valid0, (c == 3));
            end
        end
        @(posedge clk);
        #1;
        wait_cycles(4);
        n_cmp++; if (obs0.size() != 1) begin n_bad++; $display("FAIL acc_count: got %0d want 1", obs0.size()); end
        n_cmp++;
        if (obs0.size() == 0 || obs0[0] !== mk(1'b0, 70)) begin
            n_bad++;
            $display("FAIL acc_value: got %0d want 70", (obs0.size() == 0) ? 0 : $signed(obs0[0][16:0]));
        end
    endtask

    task automatic test_backpressure();
        logic [17:0] got;
        int          stalls;
        stalls = 0;
        clear_q();
        fork
            begin
                for (int i = 0; i < 8; i++) send(i, i, 1'b0, 1'b0, 1'b0);
                idle();
            end
            begin
                for (int c = 0; c < 24; c++) begin
                    out_ready = !(c >= 4 && c <= 8);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
            begin
                bit          pv;
                logic [17:0] pd;
                pv = 1'b0;
                pd = '0;
                for (int c = 0; c < 24; c++) begin
                    @(negedge clk);
                    n_cmp++;
                    if (in_ready0 !== (!out_valid0 || out_ready)) begin
                        n_bad++;
                        $display("FAIL bp_in_ready[%0d]: got %b want %b", c, in_ready0, (!out_valid0 || out_ready));
                    end
                    if (pv) begin
                        n_cmp++;
                        if (out_valid0 !== 1'b1 || {out_sat0, out_data0} !== pd) begin
                            n_bad++;
                            $display("FAIL bp_hold[%0d]: got valid=%b data=%0d want valid=1 data=%0d", c, out_valid0, out_data0, pd[16:0]);
                        end
                    end
                    if (in_ready0 === 1'b0) stalls++;
                    pv = out_valid0 && !out_ready;
                    pd = {out_sat0, out_data0};
                end
            end
        join
        wait_cycles(4);
        n_cmp++; if (stalls == 0) begin n_bad++; $display("FAIL bp_stall_seen: got 0 stalled cycles want >0"); end
        n_cmp++; if (obs0.size() != 8) begin n_bad++; $display("FAIL bp_count: got %0d want 8", obs0.size()); end
        for (int i = 0; i < 8; i++) begin
            got = (i < obs0.size()) ? obs0[i] : 18'bx;
            n_cmp++;
            if (got !== mk(1'b0, i * i)) begin
                n_bad++;
                $display("FAIL bp_data[%0d]: got %0d want %0d", i, $signed(got[16:0]), i * i);
            end
        end
    endtask

    task automatic test_interleave();
        logic [17:0] want[$];
        logic [17:0] got;
        clear_q();
        send(7, -2, 1'b1, 1'b1, 1'b1);
        send(10, 10, 1'b1, 1'b1, 1'b0);
        send(2, 2, 1'b0, 1'b0, 1'b0);
        send(1, 1, 1'b1, 1'b0, 1'b1);
        idle();
        wait_cycles(8);
        want.push_back(mk(1'b0, -14));
        want.push_back(mk(1'b0, 4));
        want.push_back(mk(1'b0, 101));
        n_cmp++; if (obs0.size() != want.size()) begin n_bad++; $display("FAIL ilv_count: got %0d want %0d", obs0.size(), want.size()); end
        foreach (want[i]) begin
            got = (i < obs0.size()) ? obs0[i] : 18'bx;
            n_cmp++;
            if (got !== want[i]) begin
                n_bad++;
                $display("FAIL ilv[%0d]: got %0d want %0d", i, $signed(got[16:0]), $signed(want[i][16:0]));
            end
        end
    endtask

    task automatic test_reset_mid_sum();
        clear_q();
        send(3, 3, 1'b1, 1'b1, 1'b0);
        send(4, 4, 1'b1, 1'b0, 1'b0);
        idle();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        n_cmp++; if (out_valid0 !== 1'b0) begin n_bad++; $display("FAIL rms_valid_in_rst: got %b want 0", out_valid0); end
        n_cmp++; if (in_ready0 !== 1'b0) begin n_bad++; $display("FAIL rms_ready_in_rst: got %b want 0", in_ready0); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(1, 5, 1'b1, 1'b1, 1'b1);
        idle();
        wait_cycles(8);
        n_cmp++; if (obs0.size() != 1) begin n_bad++; $display("FAIL rms_count: got %0d want 1", obs0.size()); end
        n_cmp++;
        if (obs0.size() == 0 || obs0[0] !== mk(1'b0, 5)) begin
            n_bad++;
            $display("FAIL rms_value: got %0d want 5", (obs0.size() == 0) ? 0 : $signed(obs0[0][16:0]));
        end
    endtask

    task automatic test_frac_wrap();
        logic [17:0] w0[$], w1[$], w2[$];
        logic [17:0] got;
        clear_q();
        send(16, -17, 1'b0, 1'b0, 1'b0);
        send(1, -1, 1'b0, 1'b0, 1'b0);
        send(4095, 65535, 1'b1, 1'b1, 1'b0);
        send(4095, 65535, 1'b1, 1'b0, 1'b0);
        send(4095, 34, 1'b1, 1'b0, 1'b1);
        idle();
        wait_cycles(8);
        w0.push_back(mk(1'b0, -272)); w0.push_back(mk(1'b0, -1)); w0.push_back(mk(1'b1, 65535));
        w1.push_back(mk(1'b0, -17));  w1.push_back(mk(1'b0, -1)); w1.push_back(mk(1'b1, 65535));
        w2.push_back(mk(1'b0, -272)); w2.push_back(mk(1'b0, -1)); w2.push_back(mk(1'b0, -32));
        n_cmp++;
        if (obs0.size() != 3 || obs1.size() != 3 || obs2.size() != 3) begin
            n_bad++;
            $display("FAIL fw_count: got %0d/%0d/%0d want 3/3/3", obs0.size(), obs1.size(), obs2.size());
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < obs0.size()) ? obs0[i] : 18'bx;
            n_cmp++; if (got !== w0[i]) begin n_bad++; $display("FAIL fw_def[%0d]: got sat=%b data=%0d want sat=%b data=%0d", i, got[17], $signed(got[16:0]), w0[i][17], $signed(w0[i][16:0])); end
            got = (i < obs1.size()) ? obs1[i] : 18'bx;
            n_cmp++; if (got !== w1[i]) begin n_bad++; $display("FAIL fw_shift4[%0d]: got sat=%b data=%0d want sat=%b data=%0d", i, got[17], $signed(got[16:0]), w1[i][17], $signed(w1[i][16:0])); end
            got = (i < obs2.size()) ? obs2[i] : 18'bx;
            n_cmp++; if (got !== w2[i]) begin n_bad++; $display("FAIL fw_acc29[%0d]: got sat=%b data=%0d want sat=%b data=%0d", i, got[17], $signed(got[16:0]), w2[i][17], $signed(w2[i][16:0])); end
        end
    endtask

    task automatic test_random();
        bit          done;
        logic [17:0] got;
        done = 1'b0;
        clear_q();
        fork
            begin
                for (int n = 0; n < 80; n++) begin
                    send($urandom_range(0, 4095), int'($urandom_range(0, 131071)) - 65536,
                         $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                         $urandom_range(0, 2) == 0);
                    if ($urandom_range(0, 4) == 0) begin
                        idle();
                        wait_cycles(1);
                    end
                end
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_cycles(10);
        n_cmp++;
        if (obs0.size() != exp0.size() || obs1.size() != exp1.size() || obs2.size() != exp2.size()) begin
            n_bad++;
            $display("FAIL rnd_count: got %0d/%0d/%0d want %0d/%0d/%0d", obs0.size(), obs1.size(), obs2.size(), exp0.size(), exp1.size(), exp2.size());
        end
        foreach (exp0[i]) begin
            got = (i < obs0.size()) ? obs0[i] : 18'bx;
            n_cmp++; if (got !== exp0[i]) begin n_bad++; $display("FAIL rnd_def[%0d]: got %h want %h", i, got, exp0[i]); end
        end
        foreach (exp1[i]) begin
            got = (i < obs1.size()) ? obs1[i] : 18'bx;
            n_cmp++; if (got !== exp1[i]) begin n_bad++; $display("FAIL rnd_shift4[%0d]: got %h want %h", i, got, exp1[i]); end
        end
        foreach (exp2[i]) begin
            got = (i < obs2.size()) ? obs2[i] : 18'bx;
            n_cmp++; if (got !== exp2[i]) begin n_bad++; $display("FAIL rnd_acc29[%0d]: got %h want %h", i, got, exp2[i]); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_mode0();
        test_accumulate();
        test_backpressure();
        test_interleave();
        test_reset_mid_sum();
        test_frac_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gcn_mac_pipe.md
# gcn_mac_pipe

Parametrised, fully pipelined unsigned-by-signed multiply / multiply-accumulate unit with valid/ready flow control, for the GCN aggregation and combination datapaths. It generalises the fixed 12x17 single-product multiplier with configurable operand widths and multiplier depth. It adds an accumulate mode with first/last framing, a fixed-point output shift with saturation, and full backpressure support. It sits between the feature/weight fetch stage and the result write-back buffer.

## Interface
- A_W, 12, width of unsigned operand a
- B_W, 17, width of signed operand b
- ACC_W, 40, accumulator width (two's complement, must be >= A_W+B_W)
- OUT_W, 17, signed output width
- FRAC_SHIFT, 0, arithmetic right shift applied before saturation (0..ACC_W-1)
- MUL_STAGES, 2, multiplier register stages (>= 1)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  unit accepts a beat this cycle
- a  in  A_W  unsigned operand
- b  in  B_W  signed operand
- mode  in  1  per-beat: 0 = plain product, 1 = accumulate
- in_first  in  1  mode 1: beat starts a new sum
- in_last  in  1  mode 1: beat closes the sum and emits it
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  OUT_W  signed result
- out_sat  out  1  out_data was clipped (qualified by out_valid)

## Operation
- Beat accepted when in_valid && in_ready. Result transferred when out_valid && out_ready.
- advance = !out_valid || out_ready; in_ready = advance && !rst. All pipeline registers, valid bits and the accumulator update only when advance=1 (global stall otherwise; no bubbles are collapsed).
- Product: p = $signed({1'b0,a}) * $signed(b), width A_W+B_W, exact. It is carried through MUL_STAGES registers along with valid, mode, first and last.
- Accumulate stage (one register stage), on a valid beat leaving the multiplier:
  - mode 0: result = sign-extend(p). Accumulator is untouched. Result is emitted.
  - mode 1, first=1: acc = p. Otherwise: acc = acc + p, wrapping modulo 2^ACC_W.
  - mode 1: a result is emitted only when last=1, with result = the new acc value. first=last=1 emits p.
  - mode 1, first=0 with no open sum (e.g. after reset): the beat adds to the current acc value (0 after reset). This is not an error.
- Output conversion: s = result >>> FRAC_SHIFT. If s > 2^(OUT_W-1)-1, out_data = max and out_sat = 1. If s < -2^(OUT_W-1), out_data = min and out_sat = 1. Otherwise out_data = s[OUT_W-1:0] and out_sat = 0.
- out_data and out_sat are registered and held stable while out_valid && !out_ready.

## Timing
- Reset values: all stage valid bits 0, acc 0, out_valid 0, out_data 0, out_sat 0. in_ready is 0 during rst and 1 in the first cycle after release.
- Latency: with no stalls, a beat accepted at edge N emits at edge N+MUL_STAGES+1 (mode 0, or the mode-1 last beat).
- Throughput: 1 beat/cycle sustained when out_ready=1.
- Stall: when out_ready=0 with out_valid=1, in_ready drops in the same cycle (combinational). No beat is lost, duplicated or reordered.
- Reset mid-sum: the pending sum is discarded and in-flight beats are dropped. No output is emitted for them.
- Mode 0 beats interleaved inside an open mode-1 sum pass through in order and do not disturb acc.

## Test plan
- Mode 0, defaults: (a=3, b=-5) -> out_data=-15, out_sat=0, out_valid at edge N+3. (a=4095, b=-65536) -> out_data=-65536, out_sat=1. (a=4095, b=65535) -> out_data=65535, out_sat=1.
- Accumulate: (1,100, first), (2,-30), (3,10, last) back to back -> exactly one output, 70, 3 cycles after the last beat. No out_valid for the first two beats.
- Backpressure: stream 8 mode-0 beats (a=i, b=i) with out_ready low for cycles 4-8 -> in_ready mirrors the stall. Outputs are 0,1,4,...,49 in order, each held stable while stalled.
- Single-beat sum plus interleave: (7,-2, first+last) -> -14. A mode-0 beat (2,2) issued between the beats of a 2-beat sum (10,10),(1,1) -> outputs 4, then 101.
- Reset mid-sum: 2 beats of an open sum, then rst for 1 cycle, then (1,5, first+last) -> the only output is 5, with out_valid=0 throughout reset.
- FRAC_SHIFT=4 instance: (16,-17) -> -17. (1,-1) -> -1 (arithmetic shift floors). ACC_W wrap checked with ACC_W=A_W+B_W and repeated max products.
